// File: rtl/turn_sequencer.sv
// turn_sequencer: runs one Connect Four turn around the shared board RAM and
// the external victory_checker. It clears the board after reset and on
// new_game. A turn takes a column, scans it for the lowest empty row, writes
// the piece, runs the checker, then declares a win or draw or passes the turn.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   new_game                      pulse: abort, clear board, P1 to move
//   move_valid/move_col/move_ready  column request handshake (ready only in IDLE)
//   illegal_move                  pulse: out-of-range column or full column
//   rd_row/rd_col/rd_data         board read port (combinational RAM)
//   wr_en/wr_row/wr_col/wr_data   board write port
//   vc_start/vc_row/vc_col        checker launch and placed-piece location
//   vc_row_read/vc_col_read/vc_data  checker's view of the board read port
//   vc_done/vc_winner             checker completion and sticky winner
//   vc_clr_n                      active-low checker clear, low while clearing
//   cur_player/game_over/winner/draw  game status
module turn_sequencer #(
    parameter int unsigned ROWS = 6,
    parameter int unsigned COLS = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       move_valid,
    input  logic [2:0] move_col,
    output logic       move_ready,
    output logic       illegal_move,
    output logic [2:0] rd_row,
    output logic [2:0] rd_col,
    input  logic [1:0] rd_data,
    output logic       wr_en,
    output logic [2:0] wr_row,
    output logic [2:0] wr_col,
    output logic [1:0] wr_data,
    output logic       vc_start,
    output logic [2:0] vc_row,
    output logic [2:0] vc_col,
    input  logic [2:0] vc_row_read,
    input  logic [2:0] vc_col_read,
    output logic [1:0] vc_data,
    input  logic       vc_done,
    input  logic [1:0] vc_winner,
    output logic       vc_clr_n,
    output logic [1:0] cur_player,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       draw
);

    localparam int unsigned AW    = 3;
    localparam int unsigned PW    = 2;
    localparam int unsigned MCW   = 6;
    localparam int unsigned CELLS = ROWS * COLS;

    localparam logic [PW-1:0] CELL_EMPTY = 2'b00;
    localparam logic [PW-1:0] PLAYER_1   = 2'b01;
    localparam logic [PW-1:0] PLAYER_2   = 2'b10;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_SCAN,
        S_WRITE,
        S_START,
        S_WAIT,
        S_UPDATE,
        S_OVER
    } state_t;

    state_t          state, state_d;
    logic [AW-1:0]   clr_row, clr_row_d;
    logic [AW-1:0]   clr_col, clr_col_d;
    logic [AW-1:0]   scan_row, scan_row_d;
    logic [AW-1:0]   scan_col, scan_col_d;
    logic [MCW-1:0]  move_cnt, move_cnt_d;

    logic            move_ready_d;
    logic            illegal_move_d;
    logic            wr_en_d;
    logic [AW-1:0]   wr_row_d;
    logic [AW-1:0]   wr_col_d;
    logic [PW-1:0]   wr_data_d;
    logic            vc_start_d;
    logic [AW-1:0]   vc_row_d;
    logic [AW-1:0]   vc_col_d;
    logic            vc_clr_n_d;
    logic [PW-1:0]   cur_player_d;
    logic            game_over_d;
    logic [PW-1:0]   winner_d;
    logic            draw_d;

    // Single read port: the checker owns it only while we wait on it.
    always_comb begin
        rd_row  = (state == S_WAIT) ? vc_row_read : scan_row;
        rd_col  = (state == S_WAIT) ? vc_col_read : scan_col;
        vc_data = rd_data;
    end

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        state_d        = state;
        clr_row_d      = clr_row;
        clr_col_d      = clr_col;
        scan_row_d     = scan_row;
        scan_col_d     = scan_col;
        move_cnt_d     = move_cnt;
        illegal_move_d = 1'b0;
        wr_en_d        = 1'b0;
        wr_row_d       = wr_row;
        wr_col_d       = wr_col;
        wr_data_d      = wr_data;
        vc_start_d     = 1'b0;
        vc_row_d       = vc_row;
        vc_col_d       = vc_col;
        cur_player_d   = cur_player;
        game_over_d    = game_over;
        winner_d       = winner;
        draw_d         = draw;

        case (state)
            S_CLEAR: begin
                // One cell per cycle, row-major from (0,0).
                wr_en_d   = 1'b1;
                wr_row_d  = clr_row;
                wr_col_d  = clr_col;
                wr_data_d = CELL_EMPTY;
                if (clr_col == AW'(COLS - 1)) begin
                    clr_col_d = '0;
                    if (clr_row == AW'(ROWS - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        clr_row_d = clr_row + AW'(1);
                    end
                end else begin
                    clr_col_d = clr_col + AW'(1);
                end
            end
            S_IDLE: begin
                if (move_valid && move_ready) begin
                    if (32'(move_col) >= COLS) begin
                        illegal_move_d = 1'b1;
                    end else begin
                        scan_col_d = move_col;
                        scan_row_d = '0;
                        state_d    = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                if (rd_data == CELL_EMPTY) begin
                    // Piece write is launched here so wr_en is high during WRITE.
                    vc_row_d  = scan_row;
                    vc_col_d  = scan_col;
                    wr_en_d   = 1'b1;
                    wr_row_d  = scan_row;
                    wr_col_d  = scan_col;
                    wr_data_d = cur_player;
                    state_d   = S_WRITE;
                end else if (scan_row == AW'(ROWS - 1)) begin
                    illegal_move_d = 1'b1;
                    state_d        = S_IDLE;
                end else begin
                    scan_row_d = scan_row + AW'(1);
                end
            end
            S_WRITE: begin
                move_cnt_d = move_cnt + MCW'(1);
                vc_start_d = 1'b1;
                state_d    = S_START;
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (vc_done) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (vc_winner != CELL_EMPTY) begin
                    winner_d    = vc_winner;
                    game_over_d = 1'b1;
                    state_d     = S_OVER;
                end else if (move_cnt == MCW'(CELLS)) begin
                    draw_d      = 1'b1;
                    game_over_d = 1'b1;
                    state_d     = S_OVER;
                end else begin
                    cur_player_d = (cur_player == PLAYER_1) ? PLAYER_2 : PLAYER_1;
                    state_d      = S_IDLE;
                end
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase

        // new_game overrides everything, including an in-flight check.
        if (new_game) begin
            state_d        = S_CLEAR;
            clr_row_d      = '0;
            clr_col_d      = '0;
            scan_row_d     = '0;
            scan_col_d     = '0;
            move_cnt_d     = '0;
            illegal_move_d = 1'b0;
            wr_en_d        = 1'b0;
            wr_row_d       = '0;
            wr_col_d       = '0;
            wr_data_d      = CELL_EMPTY;
            vc_start_d     = 1'b0;
            vc_row_d       = '0;
            vc_col_d       = '0;
            cur_player_d   = PLAYER_1;
            game_over_d    = 1'b0;
            winner_d       = CELL_EMPTY;
            draw_d         = 1'b0;
        end

        move_ready_d = (state_d == S_IDLE);
        vc_clr_n_d   = (state_d != S_CLEAR);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_CLEAR;
            clr_row      <= '0;
            clr_col      <= '0;
            scan_row     <= '0;
            scan_col     <= '0;
            move_cnt     <= '0;
            move_ready   <= 1'b0;
            illegal_move <= 1'b0;
            wr_en        <= 1'b0;
            wr_row       <= '0;
            wr_col       <= '0;
            wr_data      <= CELL_EMPTY;
            vc_start     <= 1'b0;
            vc_row       <= '0;
            vc_col       <= '0;
            vc_clr_n     <= 1'b0;
            cur_player   <= PLAYER_1;
            game_over    <= 1'b0;
            winner       <= CELL_EMPTY;
            draw         <= 1'b0;
        end else begin
            state        <= state_d;
            clr_row      <= clr_row_d;
            clr_col      <= clr_col_d;
            scan_row     <= scan_row_d;
            scan_col     <= scan_col_d;
            move_cnt     <= move_cnt_d;
            move_ready   <= move_ready_d;
            illegal_move <= illegal_move_d;
            wr_en        <= wr_en_d;
            wr_row       <= wr_row_d;
            wr_col       <= wr_col_d;
            wr_data      <= wr_data_d;
            vc_start     <= vc_start_d;
            vc_row       <= vc_row_d;
            vc_col       <= vc_col_d;
            vc_clr_n     <= vc_clr_n_d;
            cur_player   <= cur_player_d;
            game_over    <= game_over_d;
            winner       <= winner_d;
            draw         <= draw_d;
        end
    end

endmodule
